// File: rtl/cpu_gen2_pkg.sv
// Shared types and instruction field positions for the cpu_gen2 accumulator CPU.
package cpu_gen2_pkg;

  typedef enum logic [2:0] {
    OP_ADD    = 3'b000,
    OP_SUB    = 3'b001,
    OP_AND    = 3'b010,
    OP_OR     = 3'b011,
    OP_XOR    = 3'b100,
    OP_PASS_A = 3'b101,
    OP_PASS_B = 3'b110,
    OP_SHL    = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    COND_ALWAYS  = 2'b00,
    COND_ZERO    = 2'b01,
    COND_NEG     = 2'b10,
    COND_NONZERO = 2'b11
  } cond_e;

  // ALU-format instruction field positions
  localparam int unsigned DEST_AR  = 14;
  localparam int unsigned DEST_MR  = 13;
  localparam int unsigned DEST_MEM = 12;
  localparam int unsigned JMP      = 11;
  localparam int unsigned COND_HI  = 10;
  localparam int unsigned COND_LO  = 9;
  localparam int unsigned OP_HI    = 8;
  localparam int unsigned OP_LO    = 6;
  localparam int unsigned ASEL     = 5;
  localparam int unsigned BSEL     = 4;
  localparam int unsigned CONST_HI = 3;

endpackage

// File: rtl/cpu_gen2_alu.sv
// Combinational ALU for cpu_gen2; all arithmetic wraps modulo 2^WIDTH.
module cpu_gen2_alu
  import cpu_gen2_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_e          op,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_ADD:    y = a + b;
      OP_SUB:    y = a - b;
      OP_AND:    y = a & b;
      OP_OR:     y = a | b;
      OP_XOR:    y = a ^ b;
      OP_PASS_A: y = a;
      OP_PASS_B: y = b;
      OP_SHL:    y = {a[WIDTH-2:0], 1'b0};
      default:   y = '0;
    endcase
  end

endmodule

// File: rtl/cpu_gen2.sv
// Single-cycle parametrised accumulator CPU with PC, AR and MR registers.
// Optional stall input enabled by defining CPU_GEN2_STALL_EN.
module cpu_gen2
  import cpu_gen2_pkg::*;
#(
  parameter int unsigned     WIDTH    = 16,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
`ifdef CPU_GEN2_STALL_EN
  input  logic             stall,
`endif
  input  logic [WIDTH-1:0] instr,
  input  logic [WIDTH-1:0] data,
  output logic             write,
  output logic [WIDTH-1:0] dataAddr,
  output logic [WIDTH-1:0] instrAddr,
  output logic [WIDTH-1:0] result
);

  if (WIDTH < 16) begin : g_width_check
    $error("cpu_gen2: WIDTH must be at least 16");
  end

  logic [WIDTH-1:0] pc, ar, mr;
  logic [WIDTH-1:0] a_val, b_val, alu_y, const_val, pc_next;
  logic             is_const, cond_ok, jump_taken, hold;
  alu_op_e          op;
  cond_e            cond;

`ifdef CPU_GEN2_STALL_EN
  assign hold = stall;
`else
  assign hold = 1'b0;
`endif

  assign is_const  = instr[WIDTH-1];
  assign const_val = {{(WIDTH-4){1'b0}}, instr[CONST_HI:0]};
  assign a_val     = instr[ASEL] ? const_val : ar;
  assign b_val     = instr[BSEL] ? data : mr;
  assign op        = alu_op_e'(instr[OP_HI:OP_LO]);
  assign cond      = cond_e'(instr[COND_HI:COND_LO]);

  cpu_gen2_alu #(.WIDTH(WIDTH)) u_alu (
    .a  (a_val),
    .b  (b_val),
    .op (op),
    .y  (alu_y)
  );

  assign result = is_const ? '0 : alu_y;

  always_comb begin
    cond_ok = 1'b0;
    case (cond)
      COND_ALWAYS:  cond_ok = 1'b1;
      COND_ZERO:    cond_ok = (result == '0);
      COND_NEG:     cond_ok = result[WIDTH-1];
      COND_NONZERO: cond_ok = (result != '0);
      default:      cond_ok = 1'b0;
    endcase
  end

  // Jump target and write address both use the pre-edge MR.
  assign jump_taken = !is_const && instr[JMP] && cond_ok;
  assign pc_next    = jump_taken ? mr : pc + WIDTH'(1);

  assign write     = reset && !hold && !is_const && instr[DEST_MEM];
  assign dataAddr  = mr;
  assign instrAddr = pc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= RESET_PC;
      ar <= '0;
      mr <= '0;
    end else if (!hold) begin
      pc <= pc_next;
      if (is_const) begin
        mr <= {1'b0, instr[WIDTH-2:0]};
      end else begin
        if (instr[DEST_AR]) ar <= result;
        if (instr[DEST_MR]) mr <= result;
      end
    end
  end

endmodule

// File: tb/tb_cpu_gen2.sv
// Directed scoreboard bench for cpu_gen2 (WIDTH=16, RESET_PC=0).
module tb_cpu_gen2;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [15:0] instr, data;
  logic        write;
  logic [15:0] dataAddr, instrAddr, result;

  typedef struct {
    string       tag;
    logic [15:0] val;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  cpu_gen2 #(.WIDTH(16), .RESET_PC(16'h0000)) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef CPU_GEN2_STALL_EN
    .stall     (stall),
`endif
    .instr     (instr),
    .data      (data),
    .write     (write),
    .dataAddr  (dataAddr),
    .instrAddr (instrAddr),
    .result    (result)
  );

  task automatic push(input string tag, input logic [15:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [15:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed=%h expected=none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s: observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive an instruction, check the combinational result, clock it, check the next PC.
  task automatic step(input string tag, input logic [15:0] ins,
                      input logic [15:0] exp_res, input logic [15:0] exp_pc);
    @(negedge clk);
    instr = ins;
    #1;
    push({tag, "_result"}, exp_res);
    pop_check(result);
    tick();
    push({tag, "_pc"}, exp_pc);
    pop_check(instrAddr);
  endtask

  initial begin
    reset = 1'b0;
    stall = 1'b0;
    instr = 16'h1000;
    data  = 16'h0000;
    #1;
    push("rst_pc", 16'h0000);   pop_check(instrAddr);
    push("rst_ma", 16'h0000);   pop_check(dataAddr);
    push("rst_wr", 16'h0000);   pop_check({15'b0, write});
    push("rst_res", 16'h0000);  pop_check(result);

    @(negedge clk);
    reset = 1'b1;
    instr = 16'h80FF;
    #1;
    push("cl_res", 16'h0000);   pop_check(result);
    push("cl_wr", 16'h0000);    pop_check({15'b0, write});
    tick();
    push("cl_ma", 16'h00FF);    pop_check(dataAddr);
    push("cl_pc", 16'h0001);    pop_check(instrAddr);

    @(negedge clk);
    instr = 16'h4031;
    #1;
    push("alu_wr", 16'h0000);   pop_check({15'b0, write});
    push("alu_res", 16'h0001);  pop_check(result);
    tick();
    push("alu_pc", 16'h0002);   pop_check(instrAddr);

    @(negedge clk);
    instr = 16'h1140;
    #1;
    push("mem_wr", 16'h0001);   pop_check({15'b0, write});
    push("mem_res", 16'h0001);  pop_check(result);
    push("mem_ma", 16'h00FF);   pop_check(dataAddr);
    tick();
    push("mem_pc", 16'h0003);   pop_check(instrAddr);

    step("ld10", 16'h8010, 16'h0000, 16'h0004);
    push("ld10_ma", 16'h0010);  pop_check(dataAddr);
    step("ar_eq_mr", 16'h4180, 16'h0010, 16'h0005);
    step("jz_taken", 16'h0A40, 16'h0000, 16'h0010);
    step("ar_11", 16'h4021, 16'h0011, 16'h0011);
    step("jz_not", 16'h0A40, 16'h0001, 16'h0012);
    step("jneg_not", 16'h0C40, 16'h0001, 16'h0013);

    @(negedge clk);
    instr = 16'h7021;
    #1;
    push("multi_wr", 16'h0001); pop_check({15'b0, write});
    push("multi_ma", 16'h0010); pop_check(dataAddr);
    push("multi_res", 16'h0011); pop_check(result);
    tick();
    push("multi_ma2", 16'h0011); pop_check(dataAddr);
    push("multi_pc", 16'h0014);  pop_check(instrAddr);

    step("jmp_mr", 16'h2965, 16'h0005, 16'h0011);
    push("jmp_mr_ma", 16'h0005); pop_check(dataAddr);

    step("shl", 16'h01C0, 16'h0022, 16'h0012);
    step("and", 16'h0080, 16'h0001, 16'h0013);
    step("or",  16'h00C0, 16'h0015, 16'h0014);
    step("xor", 16'h0100, 16'h0014, 16'h0015);
    step("sub", 16'h0040, 16'h000C, 16'h0016);
    step("add", 16'h0000, 16'h0016, 16'h0017);
    step("jnz_taken", 16'h0E80, 16'h0001, 16'h0005);

    data = 16'hFFFF;
    step("mr_ffff", 16'h2190, 16'hFFFF, 16'h0006);
    push("mr_ffff_ma", 16'hFFFF); pop_check(dataAddr);
    step("jmp_ffff", 16'h0800, 16'h0010, 16'hFFFF);
    step("wrap", 16'h0000, 16'h0010, 16'h0000);
    step("jneg_taken", 16'h0D80, 16'hFFFF, 16'hFFFF);
    step("wrap2", 16'h0000, 16'h0010, 16'h0000);

    @(negedge clk);
    instr = 16'h1000;
    #2;
    reset = 1'b0;
    #1;
    push("async_pc", 16'h0000); pop_check(instrAddr);
    push("async_ma", 16'h0000); pop_check(dataAddr);
    push("async_wr", 16'h0000); pop_check({15'b0, write});
    instr = 16'h0140;
    #1;
    push("async_ar", 16'h0000); pop_check(result);
    @(negedge clk);
    reset = 1'b1;

`ifdef CPU_GEN2_STALL_EN
    step("ar_5", 16'h4025, 16'h0005, 16'h0001);
    @(negedge clk);
    stall = 1'b1;
    instr = 16'h5140;
    #1;
    push("stall_wr", 16'h0000);  pop_check({15'b0, write});
    push("stall_res", 16'h0005); pop_check(result);
    for (int i = 0; i < 3; i++) begin
      tick();
      push("stall_pc", 16'h0001); pop_check(instrAddr);
      push("stall_ma", 16'h0000); pop_check(dataAddr);
    end
    @(negedge clk);
    instr = 16'h0140;
    #1;
    push("stall_ar", 16'h0005);  pop_check(result);
    @(negedge clk);
    stall = 1'b0;
    instr = 16'h5140;
    #1;
    push("unstall_wr", 16'h0001); pop_check({15'b0, write});
    tick();
    push("unstall_pc", 16'h0002); pop_check(instrAddr);
`endif

    if (sb.size() != 0) begin
      errors++;
      checks++;
      $error("FAIL scoreboard_leftover: observed=%0d expected=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
